// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_REDIR = 2'd3
    } fetch_state_e;

    localparam int          INSTR_BYTES        = 4;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0040_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module   : pc
// Brief    : Program counter register with synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module pc #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] NextPC,
    output logic [WIDTH-1:0] PC
);

    logic [WIDTH-1:0] pc_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= NextPC;
        end
    end

    assign PC = pc_q;

endmodule : pc
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction fetch FSM with jump/branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEFAULT_RESET_ADDR)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Stall,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    output logic             IMemReq,
    output logic [WIDTH-1:0] IMemAddr,
    input  logic             IMemAck,
    input  logic [WIDTH-1:0] IMemRData,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Instr,
    output logic             InstrValid
);

    localparam logic [WIDTH-1:0] C_ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [WIDTH-1:0] C_PC_STEP    = WIDTH'(INSTR_BYTES);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pc_cur, pc_d, next_pc;
    logic             redirect;
    logic [WIDTH-1:0] target;

    assign redirect = Jump | BranchTaken;
    assign target   = Jump ? JumpTarget : BranchTarget;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        pc_d          = pc_cur;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (IMemAck) begin
                    // A redirect seen during the request makes the returned word stale.
                    if (redirect) begin
                        pc_d         = target;
                        pend_valid_d = 1'b0;
                        state_d      = ST_REDIR;
                    end else if (pend_valid_q) begin
                        pc_d         = pend_target_q;
                        pend_valid_d = 1'b0;
                        state_d      = ST_REDIR;
                    end else begin
                        instr_d = IMemRData;
                        state_d = ST_VALID;
                    end
                end else if (redirect) begin
                    pend_target_d = target;
                    pend_valid_d  = 1'b1;
                end
            end
            ST_VALID: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (!Stall) begin
                    pc_d    = pc_cur + C_PC_STEP;
                    state_d = ST_FETCH;
                end
            end
            ST_REDIR: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every PC load is word-aligned; hold and increment values already are.
    assign next_pc = pc_d & ~C_ALIGN_MASK;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
        end
    end

    pc #(
        .WIDTH      (WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc (
        .Clk    (Clk),
        .Reset  (~Reset_n),
        .NextPC (next_pc),
        .PC     (pc_cur)
    );

    assign PC         = pc_cur;
    assign IMemAddr   = pc_cur;
    assign Instr      = instr_q;
    assign IMemReq    = (state_q == ST_FETCH);
    assign InstrValid = (state_q == ST_VALID);

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl with a PC/Instr scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        Reset_n, Stall, Jump, BranchTaken, IMemAck;
    logic [31:0] JumpTarget, BranchTarget;
    logic        IMemReq, InstrValid;
    logic [31:0] IMemAddr, IMemRData, PC, Instr;

    int          total = 0;
    int          bad   = 0;
    logic        prev_v = 1'b0;
    logic [31:0] exp_pc_q [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign IMemRData = mem_f(IMemAddr);

    fetch_ctrl #(.WIDTH(32), .RESET_ADDR(32'h0040_0000)) dut (
        .Clk          (clk),
        .Reset_n      (Reset_n),
        .Stall        (Stall),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemRData    (IMemRData),
        .PC           (PC),
        .Instr        (Instr),
        .InstrValid   (InstrValid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then score any newly presented instruction.
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (InstrValid === 1'b1 && !prev_v) begin
            if (exp_pc_q.size() == 0) begin
                chk("sb_unexpected_valid", PC, 32'hxxxx_xxxx);
            end else begin
                e = exp_pc_q.pop_front();
                chk("sb_pc", PC, e);
                chk("sb_instr", Instr, mem_f(e));
            end
        end
        prev_v = (InstrValid === 1'b1);
    endtask

    initial begin
        Reset_n = 1'b0; Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0;
        JumpTarget = '0; BranchTarget = '0; IMemAck = 1'b1;
        tick(); tick();
        chk("rst_req", {31'd0, IMemReq}, 32'd0);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("rst_pc", PC, 32'h0040_0000);
        chk("rst_instr", Instr, 32'd0);

        // Release with ack tied high: one dead cycle then alternate-cycle fetches
        Reset_n = 1'b1;
        chk("idle_req", {31'd0, IMemReq}, 32'd0);
        exp_pc_q.push_back(32'h0040_0000);
        tick();
        chk("f0_req", {31'd0, IMemReq}, 32'd1);
        chk("f0_addr", IMemAddr, 32'h0040_0000);
        exp_pc_q.push_back(32'h0040_0004);
        tick();
        chk("v0_req", {31'd0, IMemReq}, 32'd0);
        tick();
        chk("f1_addr", IMemAddr, 32'h0040_0004);
        Stall = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {31'd0, InstrValid}, 32'd1);
            chk("stall_instr", Instr, mem_f(32'h0040_0004));
            chk("stall_req", {31'd0, IMemReq}, 32'd0);
            tick();
        end
        chk("stall_last_valid", {31'd0, InstrValid}, 32'd1);
        Stall = 1'b0;
        exp_pc_q.push_back(32'h0040_0008);
        tick();
        chk("f2_addr", IMemAddr, 32'h0040_0008);
        tick();

        // Jump beats branch
        Jump = 1'b1; JumpTarget = 32'h0040_0100;
        BranchTaken = 1'b1; BranchTarget = 32'h0040_0200;
        exp_pc_q.push_back(32'h0040_0100);
        tick();
        Jump = 1'b0; BranchTaken = 1'b0;
        chk("jump_prio_addr", IMemAddr, 32'h0040_0100);
        tick();

        // Wrap past the top of the address space
        Jump = 1'b1; JumpTarget = 32'hFFFF_FFFF;
        exp_pc_q.push_back(32'hFFFF_FFFC);
        tick();
        Jump = 1'b0;
        chk("top_addr", IMemAddr, 32'hFFFF_FFFC);
        exp_pc_q.push_back(32'h0000_0000);
        tick();
        tick();
        chk("wrap_addr", IMemAddr, 32'h0000_0000);
        tick();
        Jump = 1'b1; JumpTarget = 32'h0040_0103;
        exp_pc_q.push_back(32'h0040_0100);
        tick();
        Jump = 1'b0;
        chk("align_addr", IMemAddr, 32'h0040_0100);
        tick();

        // Branch during a slow fetch: stale data dropped, REDIR, then target
        IMemAck = 1'b0;
        tick();
        chk("slow_addr", IMemAddr, 32'h0040_0104);
        BranchTaken = 1'b1; BranchTarget = 32'h0040_0040;
        tick();
        BranchTaken = 1'b0;
        chk("pend_hold_addr", IMemAddr, 32'h0040_0104);
        chk("pend_hold_req", {31'd0, IMemReq}, 32'd1);
        tick(); tick();
        IMemAck = 1'b1;
        tick();
        chk("redir_valid", {31'd0, InstrValid}, 32'd0);
        chk("redir_req", {31'd0, IMemReq}, 32'd0);
        chk("redir_instr", Instr, mem_f(32'h0040_0100));
        exp_pc_q.push_back(32'h0040_0040);
        tick();
        chk("redir_addr", IMemAddr, 32'h0040_0040);
        tick();

        // Reset while a fetch is waiting; a late ack and a redirect in IDLE are ignored
        IMemAck = 1'b0;
        tick(); tick();
        chk("wait_addr", IMemAddr, 32'h0040_0044);
        Reset_n = 1'b0;
        tick();
        chk("mid_rst_pc", PC, 32'h0040_0000);
        chk("mid_rst_req", {31'd0, IMemReq}, 32'd0);
        chk("mid_rst_instr", Instr, 32'd0);
        Reset_n = 1'b1; IMemAck = 1'b1;
        Jump = 1'b1; JumpTarget = 32'h0040_0300;
        tick();
        Jump = 1'b0;
        chk("late_ack_valid", {31'd0, InstrValid}, 32'd0);
        chk("idle_jump_ignored", IMemAddr, 32'h0040_0000);
        exp_pc_q.push_back(32'h0040_0000);
        tick();
        tick();

        chk("sb_drained", exp_pc_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
